// File: rtl/program_counter_pkg.sv
// Shared types and defaults for the program counter and its return-address stack.
package program_counter_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_JUMP = 3'd2,
        PC_CALL = 3'd3,
        PC_RET  = 3'd4
    } pc_action_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fault_state_e;

endpackage

// File: rtl/program_counter_return_stack.sv
// LIFO return-address stack; only the pointer is reset, storage is don't-care after reset.
module return_stack
    import program_counter_pkg::*;
#(
    parameter int DATA_W = ADDR_W_DEF,
    parameter int DEPTH  = STACK_DEPTH_DEF,
    parameter int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic [PTR_W-1:0]  ptr
);

    localparam int IDX_W = PTR_W - 1;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  ptr_r;
    logic [IDX_W-1:0]  top_idx_s;

    assign full      = (ptr_r == PTR_W'(DEPTH));
    assign empty     = (ptr_r == {PTR_W{1'b0}});
    assign ptr       = ptr_r;
    // Index wraps naturally: a full stack (ptr == DEPTH) has low bits 0, minus one is DEPTH-1.
    assign top_idx_s = ptr_r[IDX_W-1:0] - {{(IDX_W-1){1'b0}}, 1'b1};
    assign top       = mem_r[top_idx_s];

    // Pointer register: push ignored when full, pop ignored when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (push && !full) begin
            ptr_r <= ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else if (pop && !empty) begin
            ptr_r <= ptr_r - {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Entry storage, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_r[ptr_r[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter.sv
// CPU program counter with call/return stack and sticky fault FSM.
// Optional build macro PROGRAM_COUNTER_HALT_ON_FAULT_EN freezes pc and stack once faulted.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_jump,
    input  logic              i_call,
    input  logic              i_ret,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_stack_full,
    output logic              o_stack_empty,
    output logic              o_fault
);

    localparam int PTR_W = $clog2(STACK_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] next_pc_s;
    logic [ADDR_W-1:0] pc_inc_s;
    logic [ADDR_W-1:0] top_s;
    logic [PTR_W-1:0]  ptr_s;
    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              active_s;
    logic              halt_s;
    logic              fault_evt_s;
    logic              ptr_bad_s;
    pc_action_e        action_s;
    fault_state_e      state_r;
    fault_state_e      next_state_s;

    assign pc_inc_s  = pc_r + ADDR_W'(1);
    // Pointer beyond depth can only arise from corruption; treat it as a fault.
    assign ptr_bad_s = (ptr_s > PTR_W'(STACK_DEPTH));

`ifdef PROGRAM_COUNTER_HALT_ON_FAULT_EN
    assign halt_s = (state_r == ST_FAULT);
`else
    assign halt_s = 1'b0;
`endif

    assign active_s = i_en && !halt_s;

    return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .PTR_W  (PTR_W)
    ) u_stack (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .top       (top_s),
        .full      (full_s),
        .empty     (empty_s),
        .ptr       (ptr_s)
    );

    // Priority decode of the control inputs into one pc action plus stack/fault strobes.
    always_comb begin
        action_s    = PC_HOLD;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        fault_evt_s = 1'b0;
        if (!active_s) begin
            action_s = PC_HOLD;
        end else if (i_call && i_ret) begin
            action_s    = PC_INC;
            fault_evt_s = 1'b1;
        end else if (i_ret) begin
            if (!empty_s) begin
                action_s = PC_RET;
                pop_s    = 1'b1;
            end else begin
                action_s    = PC_INC;
                fault_evt_s = 1'b1;
            end
        end else if (i_call) begin
            action_s    = PC_CALL;
            push_s      = !full_s;
            fault_evt_s = full_s;
        end else if (i_jump) begin
            action_s = PC_JUMP;
        end else begin
            action_s = PC_INC;
        end
        if (active_s && ptr_bad_s) begin
            fault_evt_s = 1'b1;
        end else begin
            fault_evt_s = fault_evt_s;
        end
    end

    // Next pc selection from the decoded action.
    always_comb begin
        next_pc_s = pc_r;
        case (action_s)
            PC_HOLD: next_pc_s = pc_r;
            PC_INC:  next_pc_s = pc_inc_s;
            PC_JUMP: next_pc_s = i_jump_addr;
            PC_CALL: next_pc_s = i_jump_addr;
            PC_RET:  next_pc_s = top_s;
            default: next_pc_s = pc_r;
        endcase
    end

    // Program counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_r <= {ADDR_W{1'b0}};
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Fault FSM next state: FAULT is absorbing until reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RUN:   next_state_s = fault_evt_s ? ST_FAULT : ST_RUN;
            ST_FAULT: next_state_s = ST_FAULT;
            default:  next_state_s = ST_FAULT;
        endcase
    end

    // Fault FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    assign o_pc          = pc_r;
    assign o_stack_full  = full_s;
    assign o_stack_empty = empty_s;
    assign o_fault       = (state_r == ST_FAULT);

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: a reference model queues expectations, compared after each edge.
module tb_program_counter;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_en;
    logic       i_jump;
    logic       i_call;
    logic       i_ret;
    logic [7:0] i_jump_addr;
    logic [7:0] o_pc;
    logic       o_stack_full;
    logic       o_stack_empty;
    logic       o_fault;

    typedef struct {
        logic [7:0] pc;
        logic       full;
        logic       empty;
        logic       fault;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_stack[$];
    logic [7:0] m_pc;
    logic       m_fault;
    int         n_checks;
    int         n_errors;

    program_counter dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_en          (i_en),
        .i_jump        (i_jump),
        .i_call        (i_call),
        .i_ret         (i_ret),
        .i_jump_addr   (i_jump_addr),
        .o_pc          (o_pc),
        .o_stack_full  (o_stack_full),
        .o_stack_empty (o_stack_empty),
        .o_fault       (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check_val({e.tag, "_pc"},    32'(o_pc),          32'(e.pc));
        check_val({e.tag, "_full"},  32'(o_stack_full),  32'(e.full));
        check_val({e.tag, "_empty"}, 32'(o_stack_empty), 32'(e.empty));
        check_val({e.tag, "_fault"}, 32'(o_fault),       32'(e.fault));
    endtask

    function automatic exp_t model_snapshot(input string tag);
        exp_t e;
        e.pc    = m_pc;
        e.full  = (m_stack.size() == 4);
        e.empty = (m_stack.size() == 0);
        e.fault = m_fault;
        e.tag   = tag;
        return e;
    endfunction

    task automatic do_reset(input string tag);
        i_rst_n = 1'b0;
        i_en = 1'b0; i_jump = 1'b0; i_call = 1'b0; i_ret = 1'b0; i_jump_addr = 8'h00;
        m_pc = 8'h00; m_fault = 1'b0; m_stack.delete();
        #2;
        exp_q.push_back(model_snapshot(tag));
        check_outputs(exp_q.pop_front());
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Drive one cycle of controls, advance the model, then compare after the edge.
    task automatic step(input logic en, input logic jump, input logic call, input logic ret,
                        input logic [7:0] addr, input string tag);
        logic halt;
        i_en = en; i_jump = jump; i_call = call; i_ret = ret; i_jump_addr = addr;
`ifdef PROGRAM_COUNTER_HALT_ON_FAULT_EN
        halt = m_fault;
`else
        halt = 1'b0;
`endif
        if (en && !halt) begin
            if (call && ret) begin
                m_fault = 1'b1;
                m_pc    = m_pc + 8'd1;
            end else if (ret) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_fault = 1'b1;
                    m_pc    = m_pc + 8'd1;
                end
            end else if (call) begin
                if (m_stack.size() < 4) m_stack.push_back(m_pc + 8'd1);
                else m_fault = 1'b1;
                m_pc = addr;
            end else if (jump) begin
                m_pc = addr;
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end
        exp_q.push_back(model_snapshot(tag));
        @(posedge i_clk);
        #1;
        check_outputs(exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;

        do_reset("rst0");
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "inc");
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h40, "call40");
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "ret06");

        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h80 + 8'(k * 16), "call_deep");
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "ret_lifo");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "after_lifo");

        do_reset("rst1");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h10, "jump10");
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, "ret_underflow");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "post_fault_a");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77, "post_fault_b");

        do_reset("rst2");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, "jumpFF");
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "wrap");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, "en0_jump");
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h44, "en0_call");
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, "jumpFF_2");
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h20, "call_at_max");
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, "ret_to_0");
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h60, "call_and_ret");

        #2;
        i_rst_n = 1'b0;
        #1;
        check_val("async_rst_pc",    32'(o_pc),          32'h0);
        check_val("async_rst_fault", 32'(o_fault),       32'h0);
        check_val("async_rst_empty", 32'(o_stack_empty), 32'h1);
        m_pc = 8'h00; m_fault = 1'b0; m_stack.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "post_rst_inc");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
